// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage boundary signals: PC stage handshake, instruction memory read port and decode feed.
// master = surrounding pipeline/memory, slave = the fetch stage.
interface instruction_fetch_stage_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic [ADDRESS_WIDTH-1:0] pc;
  logic                     pc_valid;
  logic                     pc_mispredict_select;
  logic                     stall_programe_counter_stage;
  logic                     mem_req;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic                     mem_ready;
  logic                     mem_rvalid;
  logic [DATA_WIDTH-1:0]    mem_rdata;
  logic                     stall_decoding_stage;
  logic [DATA_WIDTH-1:0]    instruction;
  logic [ADDRESS_WIDTH-1:0] pc_decoding;
  logic                     instruction_valid;

  modport master (
    output pc, pc_valid, pc_mispredict_select, mem_ready, mem_rvalid, mem_rdata,
           stall_decoding_stage,
    input  stall_programe_counter_stage, mem_req, mem_addr, instruction, pc_decoding,
           instruction_valid
  );

  modport slave (
    input  pc, pc_valid, pc_mispredict_select, mem_ready, mem_rvalid, mem_rdata,
           stall_decoding_stage,
    output stall_programe_counter_stage, mem_req, mem_addr, instruction, pc_decoding,
           instruction_valid
  );
endinterface

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: one outstanding instruction-memory read, small PC/word FIFO toward decode.
// Optional macro FETCH_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
//
// state      | meaning
// S_IDLE     | no read outstanding; may issue when PC valid and FIFO has room
// S_WAIT     | read outstanding; response is pushed (or bypassed)
// S_FLUSH_WAIT | read outstanding on the wrong path; response is dropped
module instruction_fetch_stage #(
  parameter int                 ADDRESS_WIDTH   = 32,
  parameter int                 DATA_WIDTH      = 32,
  parameter int                 FIFO_DEPTH      = 4,
  parameter int                 FIFO_PTR_WIDTH  = 2,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTRUCTION = 32'h00000013
) (
  input logic                      clk_i,
  input logic                      rst_n_i,
  instruction_fetch_stage_if.slave bus
);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_WAIT       = 2'd1;
  localparam logic [1:0] S_FLUSH_WAIT = 2'd2;

  localparam logic [FIFO_PTR_WIDTH:0] DEPTH_C = (FIFO_PTR_WIDTH + 1)'(FIFO_DEPTH);

  logic [1:0]                state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]  inflight_pc_q, inflight_pc_d;
  logic [FIFO_PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_PTR_WIDTH:0]   count_q, count_d;
  logic [ADDRESS_WIDTH-1:0]  pc_mem_q   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]     data_mem_q [FIFO_DEPTH];

  logic flush, fifo_empty, room, mem_req, accept, rsp, push, pop;
  logic bypass_hit, bypass_taken;

  assign flush      = bus.pc_mispredict_select;
  assign fifo_empty = (count_q == '0);
  assign room       = (count_q < DEPTH_C);
  // Gated by reset so nothing is requested while the block is held in reset.
  assign mem_req    = rst_n_i & (state_q == S_IDLE) & bus.pc_valid & room & ~flush;
  assign accept     = mem_req & bus.mem_ready;
  assign rsp        = (state_q == S_WAIT) & bus.mem_rvalid;

`ifdef FETCH_BYPASS_EN
  assign bypass_hit   = rsp & fifo_empty & ~flush;
  assign bypass_taken = bypass_hit & ~bus.stall_decoding_stage;
`else
  assign bypass_hit   = 1'b0;
  assign bypass_taken = 1'b0;
`endif

  assign push = rsp & ~flush & ~bypass_taken;
  assign pop  = ~fifo_empty & ~bus.stall_decoding_stage & ~flush;

  assign bus.mem_req  = mem_req;
  assign bus.mem_addr = bus.pc;
  // A redirect must always be loaded by the PC stage, so it is never stalled then.
  assign bus.stall_programe_counter_stage = ~rst_n_i | (~flush & ~accept);

  assign bus.instruction_valid = ~fifo_empty | bypass_hit;
  assign bus.instruction = ~fifo_empty ? data_mem_q[rd_ptr_q] :
                           bypass_hit  ? bus.mem_rdata : NOP_INSTRUCTION;
  assign bus.pc_decoding = ~fifo_empty ? pc_mem_q[rd_ptr_q] :
                           bypass_hit  ? inflight_pc_q : '0;

  always_comb begin
    state_d       = state_q;
    inflight_pc_d = inflight_pc_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          inflight_pc_d = bus.pc;
          state_d       = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.mem_rvalid)  state_d = S_IDLE;
        else if (flush)      state_d = S_FLUSH_WAIT;
      end
      S_FLUSH_WAIT: begin
        if (bus.mem_rvalid)  state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (FIFO_PTR_WIDTH + 1)'(push) - (FIFO_PTR_WIDTH + 1)'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= S_IDLE;
      inflight_pc_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      inflight_pc_q <= inflight_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
      data_mem_q[wr_ptr_q] <= bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed self-checking bench for instruction_fetch_stage; bypass expectations follow FETCH_BYPASS_EN.
module tb_instruction_fetch_stage;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  instruction_fetch_stage_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

  instruction_fetch_stage dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Issue one fetch with a one-cycle response; assumes IDLE with room.
  task automatic do_fetch(input logic [31:0] a, input logic [31:0] d);
    bus.pc = a; bus.pc_valid = 1'b1; bus.mem_ready = 1'b1;
    tick();
    bus.pc_valid = 1'b0; bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = d;
    tick();
    bus.mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.pc_valid = 1'b1; bus.pc = 32'h0; bus.mem_ready = 1'b1;
    mid();
    n_cmp++;
    if ({bus.mem_req, bus.stall_programe_counter_stage, bus.instruction_valid} !== 3'b010) begin
      n_err++;
      $display("FAIL reset_ctl: got req/stall/valid=%b want 010",
               {bus.mem_req, bus.stall_programe_counter_stage, bus.instruction_valid});
    end
    n_cmp++;
    if ({bus.instruction, bus.pc_decoding} !== {NOP, 32'h0}) begin
      n_err++;
      $display("FAIL reset_out: got instr=%h pc=%h want %h 0", bus.instruction, bus.pc_decoding, NOP);
    end
    tick();
    bus.pc_valid = 1'b0; bus.mem_ready = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_fetch();
    bus.stall_decoding_stage = 1'b0;
    bus.pc = 32'h0; bus.pc_valid = 1'b1; bus.mem_ready = 1'b1;
    mid();
    n_cmp++;
    if ({bus.mem_req, bus.stall_programe_counter_stage, bus.mem_addr} !== {2'b10, 32'h0}) begin
      n_err++;
      $display("FAIL single_req: got req=%b stall=%b addr=%h want 1 0 0",
               bus.mem_req, bus.stall_programe_counter_stage, bus.mem_addr);
    end
    tick();
    bus.pc = 32'h4;
    mid();
    n_cmp++;
    if ({bus.mem_req, bus.stall_programe_counter_stage} !== 2'b01) begin
      n_err++;
      $display("FAIL single_wait_noreq: got req=%b stall=%b want 0 1",
               bus.mem_req, bus.stall_programe_counter_stage);
    end
    tick();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h00500093;
    mid();
    n_cmp++;
    if (bus.mem_req !== 1'b0) begin
      n_err++;
      $display("FAIL single_rsp_noreq: got req=%b want 0", bus.mem_req);
    end
`ifdef FETCH_BYPASS_EN
    n_cmp++;
    if ({bus.instruction_valid, bus.instruction, bus.pc_decoding} !== {1'b1, 32'h00500093, 32'h0}) begin
      n_err++;
      $display("FAIL single_bypass: got v=%b instr=%h pc=%h want 1 00500093 0",
               bus.instruction_valid, bus.instruction, bus.pc_decoding);
    end
`else
    n_cmp++;
    if (bus.instruction_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_rsp_valid: got %b want 0", bus.instruction_valid);
    end
`endif
    tick();
    bus.mem_rvalid = 1'b0; bus.pc_valid = 1'b0;
    mid();
`ifdef FETCH_BYPASS_EN
    n_cmp++;
    if (bus.instruction_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_after_bypass: got valid=%b want 0", bus.instruction_valid);
    end
`else
    n_cmp++;
    if ({bus.instruction_valid, bus.instruction, bus.pc_decoding} !== {1'b1, 32'h00500093, 32'h0}) begin
      n_err++;
      $display("FAIL single_out: got v=%b instr=%h pc=%h want 1 00500093 0",
               bus.instruction_valid, bus.instruction, bus.pc_decoding);
    end
    tick();
    mid();
    n_cmp++;
    if (bus.instruction_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_popped: got valid=%b want 0", bus.instruction_valid);
    end
`endif
    tick();
  endtask

  task automatic test_full_buffer();
    bus.stall_decoding_stage = 1'b1;
    for (int i = 0; i < 4; i++) do_fetch(32'(4 * i), 32'h100 | 32'(4 * i));
    bus.pc = 32'h10; bus.pc_valid = 1'b1; bus.mem_ready = 1'b1;
    mid();
    n_cmp++;
    if ({bus.mem_req, bus.stall_programe_counter_stage, bus.instruction_valid, bus.pc_decoding,
         bus.instruction} !== {3'b011, 32'h0, 32'h100}) begin
      n_err++;
      $display("FAIL full_block: got req=%b stall=%b v=%b pc=%h instr=%h want 0 1 1 0 100",
               bus.mem_req, bus.stall_programe_counter_stage, bus.instruction_valid,
               bus.pc_decoding, bus.instruction);
    end
    tick();
    bus.stall_decoding_stage = 1'b0;
    mid();
    n_cmp++;
    if ({bus.mem_req, bus.pc_decoding} !== {1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL full_room_before_pop: got req=%b pc=%h want 0 0", bus.mem_req, bus.pc_decoding);
    end
    tick();
    bus.stall_decoding_stage = 1'b1;
    mid();
    n_cmp++;
    if ({bus.mem_req, bus.stall_programe_counter_stage, bus.mem_addr, bus.pc_decoding} !==
        {2'b10, 32'h10, 32'h4}) begin
      n_err++;
      $display("FAIL full_issue: got req=%b stall=%b addr=%h head=%h want 1 0 10 4",
               bus.mem_req, bus.stall_programe_counter_stage, bus.mem_addr, bus.pc_decoding);
    end
    tick();
    bus.pc_valid = 1'b0; bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h110;
    tick();
    bus.mem_rvalid = 1'b0; bus.stall_decoding_stage = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      mid();
      n_cmp++;
      if ({bus.instruction_valid, bus.pc_decoding, bus.instruction} !==
          {1'b1, 32'(4 * i), 32'h100 | 32'(4 * i)}) begin
        n_err++;
        $display("FAIL full_drain%0d: got v=%b pc=%h instr=%h want 1 %h %h", i,
                 bus.instruction_valid, bus.pc_decoding, bus.instruction, 4 * i, 32'h100 | 32'(4 * i));
      end
      tick();
    end
    mid();
    n_cmp++;
    if (bus.instruction_valid !== 1'b0) begin
      n_err++;
      $display("FAIL full_drained: got valid=%b want 0", bus.instruction_valid);
    end
    tick();
  endtask

  task automatic test_flush_wait();
    bus.stall_decoding_stage = 1'b0;
    bus.pc = 32'h8; bus.pc_valid = 1'b1; bus.mem_ready = 1'b1;
    tick();
    bus.pc = 32'h40; bus.pc_mispredict_select = 1'b1;
    mid();
    n_cmp++;
    if ({bus.mem_req, bus.stall_programe_counter_stage} !== 2'b00) begin
      n_err++;
      $display("FAIL flush_stall: got req=%b stall=%b want 0 0",
               bus.mem_req, bus.stall_programe_counter_stage);
    end
    tick();
    bus.pc_mispredict_select = 1'b0; bus.pc_valid = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
    mid();
    n_cmp++;
    if ({bus.mem_req, bus.instruction_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL flush_drop_cycle: got req=%b valid=%b want 0 0", bus.mem_req, bus.instruction_valid);
    end
    tick();
    bus.mem_rvalid = 1'b0; bus.pc_valid = 1'b1;
    mid();
    n_cmp++;
    if ({bus.instruction_valid, bus.mem_req, bus.mem_addr} !== {2'b01, 32'h40}) begin
      n_err++;
      $display("FAIL flush_new_req: got valid=%b req=%b addr=%h want 0 1 40",
               bus.instruction_valid, bus.mem_req, bus.mem_addr);
    end
    tick();
    bus.pc_valid = 1'b0; bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h12345678;
`ifdef FETCH_BYPASS_EN
    mid();
    n_cmp++;
    if ({bus.instruction_valid, bus.pc_decoding, bus.instruction} !== {1'b1, 32'h40, 32'h12345678}) begin
      n_err++;
      $display("FAIL flush_new_bypass: got v=%b pc=%h instr=%h want 1 40 12345678",
               bus.instruction_valid, bus.pc_decoding, bus.instruction);
    end
    tick();
    bus.mem_rvalid = 1'b0;
`else
    tick();
    bus.mem_rvalid = 1'b0;
    mid();
    n_cmp++;
    if ({bus.instruction_valid, bus.pc_decoding, bus.instruction} !== {1'b1, 32'h40, 32'h12345678}) begin
      n_err++;
      $display("FAIL flush_new_word: got v=%b pc=%h instr=%h want 1 40 12345678",
               bus.instruction_valid, bus.pc_decoding, bus.instruction);
    end
    tick();
`endif
    mid();
    n_cmp++;
    if (bus.instruction_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_no_stale: got valid=%b want 0", bus.instruction_valid);
    end
    tick();
  endtask

  task automatic test_flush_rvalid();
    bus.stall_decoding_stage = 1'b1;
    do_fetch(32'h20, 32'hA0000020);
    do_fetch(32'h24, 32'hA0000024);
    bus.pc = 32'h28; bus.pc_valid = 1'b1; bus.mem_ready = 1'b1;
    mid();
    n_cmp++;
    if ({bus.mem_req, bus.pc_decoding} !== {1'b1, 32'h20}) begin
      n_err++;
      $display("FAIL fr_issue: got req=%b head=%h want 1 20", bus.mem_req, bus.pc_decoding);
    end
    tick();
    bus.pc_valid = 1'b0; bus.mem_ready = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hA0000028; bus.pc_mispredict_select = 1'b1;
    mid();
    n_cmp++;
    if ({bus.stall_programe_counter_stage, bus.instruction_valid} !== 2'b01) begin
      n_err++;
      $display("FAIL fr_flush_cycle: got stall=%b valid=%b want 0 1",
               bus.stall_programe_counter_stage, bus.instruction_valid);
    end
    tick();
    bus.mem_rvalid = 1'b0; bus.pc_mispredict_select = 1'b0;
    bus.pc = 32'h80; bus.pc_valid = 1'b1;
    mid();
    n_cmp++;
    if ({bus.mem_req, bus.stall_programe_counter_stage, bus.instruction_valid} !== 3'b110) begin
      n_err++;
      $display("FAIL fr_after: got req=%b stall=%b valid=%b want 1 1 0",
               bus.mem_req, bus.stall_programe_counter_stage, bus.instruction_valid);
    end
    tick();
    bus.pc_valid = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    bus.stall_decoding_stage = 1'b1;
    do_fetch(32'h50, 32'hA0000050);
    bus.pc = 32'h60; bus.pc_valid = 1'b1; bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.mem_req, bus.stall_programe_counter_stage, bus.instruction_valid, bus.instruction,
         bus.pc_decoding} !== {3'b010, NOP, 32'h0}) begin
      n_err++;
      $display("FAIL rst_async: got req=%b stall=%b v=%b instr=%h pc=%h want 0 1 0 %h 0",
               bus.mem_req, bus.stall_programe_counter_stage, bus.instruction_valid,
               bus.instruction, bus.pc_decoding, NOP);
    end
    tick();
    rst_n = 1'b1; bus.pc_valid = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0BAD0BAD;
    mid();
    n_cmp++;
    if ({bus.mem_req, bus.instruction_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_stale_cycle: got req=%b valid=%b want 0 0", bus.mem_req, bus.instruction_valid);
    end
    tick();
    bus.mem_rvalid = 1'b0;
    mid();
    n_cmp++;
    if (bus.instruction_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_stale_ignored: got valid=%b want 0", bus.instruction_valid);
    end
    tick();
  endtask

  initial begin
    bus.pc = '0; bus.pc_valid = 1'b0; bus.pc_mispredict_select = 1'b0;
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    bus.stall_decoding_stage = 1'b0;
    test_reset();
    test_single_fetch();
    test_full_buffer();
    test_flush_wait();
    test_flush_rvalid();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
